// File: rtl/seq_det_pkg.sv
// Shared constants for the 10010 serial pattern detector: state encoding,
// the pattern itself and a helper returning the bit each state expects next.
package seq_det_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned PAT_LEN = 5;

    localparam logic [PAT_LEN-1:0] PATTERN = 5'b10010;

    // Each state is named by the longest pattern prefix matched so far
    localparam logic [STATE_W-1:0] S0 = STATE_W'(0);
    localparam logic [STATE_W-1:0] S1 = STATE_W'(1);
    localparam logic [STATE_W-1:0] S2 = STATE_W'(2);
    localparam logic [STATE_W-1:0] S3 = STATE_W'(3);
    localparam logic [STATE_W-1:0] S4 = STATE_W'(4);
    localparam logic [STATE_W-1:0] S5 = STATE_W'(5);

    // Pattern bit that extends a match of length idx (first pattern bit is the MSB)
    function automatic logic pat_bit(input logic [STATE_W-1:0] idx);
        logic [PAT_LEN-1:0] w_sh;
        w_sh = PATTERN << idx;
        return w_sh[PAT_LEN-1];
    endfunction

endpackage

// File: rtl/seq_det.sv
// Moore detector for the overlapping serial pattern 10010; z pulses for one
// cycle after the fifth pattern bit is sampled.
module seq_det
    import seq_det_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic x,
    output logic z
);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic               r_z;

    // A mismatch on any partial prefix falls back to "1" or nothing, depending on x
    always_comb begin
        w_next = S0;
        case (r_state)
            S0, S1, S2, S3, S4: begin
                if (x == pat_bit(r_state)) begin
                    w_next = STATE_W'(r_state + STATE_W'(1));
                end else begin
                    w_next = x ? S1 : S0;
                end
            end
            S5:      w_next = x ? S1 : S3;
            default: w_next = S0;
        endcase
    end

    // State register with async clear; the match flag is registered alongside it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S0;
            r_z     <= 1'b0;
        end else begin
            r_state <= w_next;
            r_z     <= (w_next == S5);
        end
    end

    assign z = r_z;

endmodule

// File: tb/tb_seq_det.sv
// Directed self-checking bench for seq_det (pattern 10010, overlapping, Moore output).
module tb_seq_det;

    logic clk;
    logic rst;
    logic x;
    logic z;

    int n_checks;
    int n_fail;

    seq_det dut (
        .clk (clk),
        .rst (rst),
        .x   (x),
        .z   (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one bit between edges, then settle just after the sampling edge
    task automatic step(input logic b);
        @(negedge clk);
        x = b;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        x   = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        x   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            x = ~x;
            @(posedge clk);
            #1;
            n_checks++;
            if (z !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold[%0d]: z=%b expected 0", i, z);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        x   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            n_checks++;
            if (z !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release[%0d]: z=%b expected 0", i, z);
            end
        end
    endtask

    task automatic test_single();
        logic [5:0] seq_v;
        logic [5:0] exp_v;
        seq_v = 6'b100100;
        exp_v = 6'b000010;
        do_reset();
        for (int i = 5; i >= 0; i--) begin
            step(seq_v[i]);
            n_checks++;
            if (z !== exp_v[i]) begin
                n_fail++;
                $display("FAIL single[%0d]: z=%b expected %b", 5 - i, z, exp_v[i]);
            end
        end
    endtask

    task automatic test_overlap();
        logic [7:0] seq_v;
        logic [7:0] exp_v;
        seq_v = 8'b10010010;
        exp_v = 8'b00001001;
        do_reset();
        for (int i = 7; i >= 0; i--) begin
            step(seq_v[i]);
            n_checks++;
            if (z !== exp_v[i]) begin
                n_fail++;
                $display("FAIL overlap[%0d]: z=%b expected %b", 7 - i, z, exp_v[i]);
            end
        end
    endtask

    task automatic test_rotating();
        logic [23:0] stream;
        logic [23:0] exp_v;
        int          pulses;
        stream = 24'b000011001001000010010100;
        exp_v  = 24'b000000000100100000001000;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            pulses = 0;
            for (int i = 0; i < 24; i++) begin
                step(stream[23 - i]);
                if (z === 1'b1) pulses++;
                n_checks++;
                if (z !== exp_v[23 - i]) begin
                    n_fail++;
                    $display("FAIL rotating[p%0d i%0d]: z=%b expected %b", p, i, z, exp_v[23 - i]);
                end
            end
            n_checks++;
            if (pulses !== 3) begin
                n_fail++;
                $display("FAIL rotating_count[p%0d]: pulses=%0d expected 3", p, pulses);
            end
        end
    endtask

    task automatic test_near_miss();
        logic [13:0] seq_v;
        logic [13:0] exp_v;
        // 100010 then 10110 then 010: the last three bits only complete a match
        // if each near-miss fell back to the correct prefix state
        seq_v = 14'b100010_10110_010;
        exp_v = 14'b000000_00000_001;
        do_reset();
        for (int i = 13; i >= 0; i--) begin
            step(seq_v[i]);
            n_checks++;
            if (z !== exp_v[i]) begin
                n_fail++;
                $display("FAIL near_miss[%0d]: z=%b expected %b", 13 - i, z, exp_v[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [4:0] pre_v;
        logic [4:0] seq_v;
        logic [4:0] exp_v;
        pre_v = 5'b10010;
        seq_v = 5'b10010;
        exp_v = 5'b00001;
        do_reset();
        for (int i = 4; i >= 1; i--) begin
            step(pre_v[i]);
            n_checks++;
            if (z !== 1'b0) begin
                n_fail++;
                $display("FAIL async_pre[%0d]: z=%b expected 0", 4 - i, z);
            end
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        #2;
        rst = 1'b1;
        step(1'b0);
        n_checks++;
        if (z !== 1'b0) begin
            n_fail++;
            $display("FAIL async_history: z=%b expected 0", z);
        end
        for (int i = 4; i >= 0; i--) begin
            step(seq_v[i]);
            n_checks++;
            if (z !== exp_v[i]) begin
                n_fail++;
                $display("FAIL async_post[%0d]: z=%b expected %b", 4 - i, z, exp_v[i]);
            end
        end
        // Reset during a pulse must clear z without waiting for a clock edge
        #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (z !== 1'b0) begin
            n_fail++;
            $display("FAIL async_clear: z=%b expected 0", z);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b0;
        x        = 1'b0;
        test_reset();
        test_single();
        test_overlap();
        test_rotating();
        test_near_miss();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
